// File: rtl/bluetooth_frame_encoder.sv
// Command-frame encoder: latches a command/payload on start, assembles SYNC/opcode/LEN/payload/CHK,
// exposes the whole frame in parallel and streams it byte-wise over valid/ready.
module bluetooth_frame_encoder #(
  parameter int          DATA_W      = 32,
  parameter int          CMD_W       = 4,
  parameter int          NUM_CMDS    = 8,
  parameter logic [7:0]  OPCODE_BASE = 8'h10,
  parameter logic [7:0]  SYNC        = 8'hAA,
  parameter int          FRAME_W     = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CMD_W-1:0]   command_select,
  input  logic [DATA_W-1:0]  input_data,
  output logic               busy,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FRAME_W-1:0] output_data,
  output logic               done,
  output logic               error
);

  localparam int PB    = DATA_W / 8;
  localparam int FB    = FRAME_W / 8;
  localparam int IDX_W = (FB > 1) ? $clog2(FB) : 1;
  localparam int NB    = 2 ** IDX_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [FRAME_W-1:0] output_data_q, output_data_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic               error_q, error_d;

  logic               cmd_valid;
  logic               has_payload;
  logic [7:0]         opcode;
  logic [7:0]         len_byte;
  logic [7:0]         chk;
  logic [FRAME_W-1:0] frame;
  logic [7:0]         frame_bytes [NB];

  assign cmd_valid   = (32'(command_select) < NUM_CMDS);
  assign has_payload = (cmd_q != '0);
  assign opcode      = OPCODE_BASE + 8'(cmd_q);
  assign len_byte    = has_payload ? 8'(PB) : 8'h00;

  // Ping frames carry no payload, so the checksum lands directly after LEN.
  always_comb begin
    frame          = '0;
    chk            = opcode ^ len_byte;
    frame[7:0]     = SYNC;
    frame[15:8]    = opcode;
    frame[23:16]   = len_byte;
    if (has_payload) begin
      for (int k = 0; k < PB; k++) begin
        frame[8*(3+k) +: 8] = data_q[8*k +: 8];
        chk                 = chk ^ data_q[8*k +: 8];
      end
      frame[8*(3+PB) +: 8] = chk;
    end else begin
      frame[31:24] = chk;
    end
  end

  // Pad the byte view to a power of two so the stream index never runs off the array.
  for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
    if (gi < FB) begin : g_used
      assign frame_bytes[gi] = output_data_q[8*gi +: 8];
    end else begin : g_pad
      assign frame_bytes[gi] = 8'h00;
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    data_d        = data_q;
    output_data_d = output_data_q;
    idx_d         = idx_q;
    last_idx_d    = last_idx_q;
    error_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cmd_valid) begin
            cmd_d   = command_select;
            data_d  = input_data;
            state_d = ST_LOAD;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        output_data_d = frame;
        idx_d         = '0;
        last_idx_d    = has_payload ? IDX_W'(PB + 3) : IDX_W'(3);
        state_d       = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          if (idx_q == last_idx_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      data_q        <= '0;
      output_data_q <= '0;
      idx_q         <= '0;
      last_idx_q    <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      data_q        <= data_d;
      output_data_q <= output_data_d;
      idx_q         <= idx_d;
      last_idx_q    <= last_idx_d;
      error_q       <= error_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = (state_q == ST_SEND);
  assign done        = (state_q == ST_DONE);
  assign error       = error_q;
  assign out_byte    = out_valid ? frame_bytes[idx_q] : 8'h00;
  assign output_data = output_data_q;

endmodule

// File: tb/tb_bluetooth_frame_encoder.sv
// Directed bench for bluetooth_frame_encoder at default parameters.
module tb_bluetooth_frame_encoder;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   command_select;
  logic [31:0]  input_data;
  logic         busy;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] output_data;
  logic         done;
  logic         error;

  int errors = 0;
  int checks = 0;

  byte unsigned got_q[$];
  byte unsigned exp_q[$];
  int           done_cyc;
  bit           timed_out;
  bit           hold_bad;

  bluetooth_frame_encoder dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .command_select (command_select),
    .input_data     (input_data),
    .busy           (busy),
    .out_byte       (out_byte),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .output_data    (output_data),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and records accepted bytes until done or a cycle budget expires.
  // cyc counts cycles after the edge that sampled start (cycle N+1 is cyc=1).
  task automatic send_frame(input logic [3:0] cmd, input logic [31:0] data,
                            input bit toggle, input bit mid_start);
    logic [7:0] prev_byte;
    bit         prev_stall;
    int         cyc;
    got_q.delete();
    done_cyc   = -1;
    timed_out  = 1'b0;
    hold_bad   = 1'b0;
    prev_stall = 1'b0;
    prev_byte  = 8'h00;
    command_select = cmd;
    input_data     = data;
    out_ready      = 1'b1;
    start          = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (cyc < 200) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      start     = mid_start && (cyc == 4 || cyc == 9);
      if (start) begin
        command_select = 4'd2;
        input_data     = 32'hCAFE_F00D;
      end
      if (prev_stall && out_byte !== prev_byte) hold_bad = 1'b1;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (out_valid && out_ready) got_q.push_back(out_byte);
      prev_stall = out_valid && !out_ready;
      prev_byte  = out_byte;
      tick();
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (done_cyc < 0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    command_select = '0; input_data = '0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({busy, out_valid, done, error, out_byte} !== 12'h000 || output_data !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got busy=%b valid=%b done=%b err=%b byte=%h od=%h want all 0",
                 i, busy, out_valid, done, error, out_byte, output_data);
      end
    end
  endtask

  task automatic test_data_frame();
    exp_q = '{8'hAA, 8'h11, 8'h04, 8'h78, 8'h56, 8'h34, 8'h12, 8'h1D};
    send_frame(4'd1, 32'h1234_5678, 1'b0, 1'b0);
    checks++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL data_len got %0d bytes timeout=%b want %0d", got_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL data_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cyc != 10) begin
      errors++;
      $display("FAIL data_done_cycle got %0d want 10", done_cyc);
    end
    checks++;
    if (output_data !== 128'h1D12_3456_7804_11AA) begin
      errors++;
      $display("FAIL data_output got %h want %h", output_data, 128'h1D12_3456_7804_11AA);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL data_after_done got done=%b busy=%b want 0 0", done, busy);
    end
    $display("data frame: %0d bytes, done at cycle %0d", got_q.size(), done_cyc);
  endtask

  task automatic test_max_cmd();
    exp_q = '{8'hAA, 8'h17, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h13};
    send_frame(4'd7, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL maxcmd_len got %0d bytes timeout=%b want %0d", got_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL maxcmd_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (output_data !== 128'h13FF_FFFF_FF04_17AA) begin
      errors++;
      $display("FAIL maxcmd_output got %h want %h", output_data, 128'h13FF_FFFF_FF04_17AA);
    end
    tick();
    $display("max cmd frame: %0d bytes, done at cycle %0d", got_q.size(), done_cyc);
  endtask

  task automatic test_ping();
    exp_q = '{8'hAA, 8'h10, 8'h00, 8'h10};
    send_frame(4'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checks++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ping_len got %0d bytes timeout=%b want %0d", got_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ping_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cyc != 6) begin
      errors++;
      $display("FAIL ping_done_cycle got %0d want 6", done_cyc);
    end
    checks++;
    if (output_data !== 128'h1000_10AA) begin
      errors++;
      $display("FAIL ping_output got %h want %h", output_data, 128'h1000_10AA);
    end
    tick();
    $display("ping frame: %0d bytes, done at cycle %0d", got_q.size(), done_cyc);
  endtask

  task automatic test_invalid_cmd();
    logic [3:0] bad_cmds [2];
    bad_cmds[0] = 4'd9;
    bad_cmds[1] = 4'd8;
    for (int c = 0; c < 2; c++) begin
      command_select = bad_cmds[c];
      input_data     = 32'h5555_AAAA;
      out_ready      = 1'b1;
      start          = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL invalid_pulse cmd=%0d got err=%b busy=%b valid=%b want 1 0 0",
                 bad_cmds[c], error, busy, out_valid);
      end
      tick();
      checks++;
      if (error !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL invalid_after cmd=%0d got err=%b busy=%b valid=%b want 0 0 0",
                 bad_cmds[c], error, busy, out_valid);
      end
      checks++;
      if (output_data !== 128'h1000_10AA) begin
        errors++;
        $display("FAIL invalid_output cmd=%0d got %h want %h", bad_cmds[c], output_data, 128'h1000_10AA);
      end
      $display("invalid cmd %0d: error pulse observed=%b", bad_cmds[c], 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    exp_q = '{8'hAA, 8'h11, 8'h04, 8'h78, 8'h56, 8'h34, 8'h12, 8'h1D};
    send_frame(4'd1, 32'h1234_5678, 1'b1, 1'b1);
    checks++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_len got %0d bytes timeout=%b want %0d", got_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stall_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (hold_bad !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold got byte change during stall=%b want 0", hold_bad);
    end
    checks++;
    if (done_cyc != 17) begin
      errors++;
      $display("FAIL stall_done_cycle got %0d want 17", done_cyc);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || output_data !== 128'h1D12_3456_7804_11AA) begin
      errors++;
      $display("FAIL stall_ignore_start got busy=%b od=%h want 0 %h", busy, output_data,
               128'h1D12_3456_7804_11AA);
    end
    $display("stalled frame: %0d bytes, done at cycle %0d", got_q.size(), done_cyc);
  endtask

  task automatic test_reset_mid();
    command_select = 4'd1;
    input_data     = 32'h1234_5678;
    out_ready      = 1'b1;
    start          = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++;
    if (out_valid !== 1'b1 || out_byte !== 8'h78) begin
      errors++;
      $display("FAIL midreset_pre got valid=%b byte=%h want 1 78", out_valid, out_byte);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, out_valid, done, error, out_byte} !== 12'h000 || output_data !== '0) begin
      errors++;
      $display("FAIL midreset_clear got busy=%b valid=%b done=%b err=%b byte=%h od=%h want all 0",
               busy, out_valid, done, error, out_byte, output_data);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_nodone cyc=%0d got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    exp_q = '{8'hAA, 8'h11, 8'h04, 8'h78, 8'h56, 8'h34, 8'h12, 8'h1D};
    send_frame(4'd1, 32'h1234_5678, 1'b0, 1'b0);
    checks++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midreset_len got %0d bytes timeout=%b want %0d", got_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    tick();
    $display("post-reset frame: %0d bytes, done at cycle %0d", got_q.size(), done_cyc);
  endtask

  initial begin
    test_reset();
    test_data_frame();
    test_max_cmd();
    test_ping();
    test_invalid_cmd();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
